// File: rtl/issue_sched_pkg.sv
// Shared sizing and offer-FSM encoding for the issue scheduler.
package issue_sched_pkg;

    localparam int unsigned NENT = 32;
    localparam int unsigned AW   = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

endpackage

// File: rtl/select_tree.sv
// Pairwise binary select tree: lowest-index asserted request wins.
module select_tree #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 5
) (
    input  logic [N-1:0] req,
    output logic         any_ready,
    output logic [W-1:0] win_idx
);

    localparam int unsigned LV = $clog2(N);

    // Level l holds N>>l nodes; each node prefers its left (lower-index) child.
    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int unsigned M = N >> l;
        logic [M-1:0]        any_v;
        logic [M-1:0][W-1:0] idx_v;

        if (l == 0) begin : g_leaf
            assign any_v = req;
            for (genvar j = 0; j < M; j++) begin : g_idx
                assign idx_v[j] = W'(j);
            end
        end else begin : g_node
            for (genvar k = 0; k < M; k++) begin : g_sel
                assign any_v[k] = g_lvl[l-1].any_v[2*k] | g_lvl[l-1].any_v[2*k+1];
                assign idx_v[k] = g_lvl[l-1].any_v[2*k] ? g_lvl[l-1].idx_v[2*k]
                                                         : g_lvl[l-1].idx_v[2*k+1];
            end
        end
    end

    assign any_ready = g_lvl[LV].any_v[0];
    assign win_idx   = g_lvl[LV].idx_v[0];

endmodule

// File: rtl/issue_sched.sv
// Issue queue scheduler: lowest-free allocation, wakeup, and a held one-at-a-time
// issue offer with back-to-back accept.
module issue_sched #(
    parameter int unsigned NENT = issue_sched_pkg::NENT,
    parameter int unsigned AW   = issue_sched_pkg::AW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          alloc_valid,
    input  logic          alloc_rdy_in,
    output logic          alloc_ready,
    output logic [AW-1:0] alloc_idx,
    input  logic          wakeup_valid,
    input  logic [AW-1:0] wakeup_idx,
    output logic          issue_valid,
    output logic [AW-1:0] issue_idx,
    input  logic          issue_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    import issue_sched_pkg::*;

    localparam int unsigned CW = AW + 1;

    logic [NENT-1:0] valid_q, valid_d;
    logic [NENT-1:0] rdy_q,   rdy_d;
    logic [NENT-1:0] pend_q,  pend_d;
    state_e          state_q, state_d;
    logic            issue_valid_q, issue_valid_d;
    logic [AW-1:0]   issue_idx_q,   issue_idx_d;
    logic [CW-1:0]   count_q,       count_d;
    logic            full_q,        full_d;
    logic            empty_q,       empty_d;
    logic            live_q;

    logic [NENT-1:0] cand;
    logic            cand_any;
    logic [AW-1:0]   cand_idx;
    logic            free_any;
    logic [AW-1:0]   free_idx;
    logic            alloc_fire;
    logic            issue_fire;

    assign cand = valid_q & rdy_q & ~pend_q;

    select_tree #(.N(NENT), .W(AW)) u_issue_sel (
        .req       (cand),
        .any_ready (cand_any),
        .win_idx   (cand_idx)
    );

    select_tree #(.N(NENT), .W(AW)) u_free_sel (
        .req       (~valid_q),
        .any_ready (free_any),
        .win_idx   (free_idx)
    );

    // live_q keeps alloc_ready low until the first edge after reset release.
    assign alloc_ready = live_q & free_any & ~flush;
    assign alloc_idx   = free_idx;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign issue_fire  = (state_q == OFFER) & issue_ready;

    always_comb begin
        valid_d       = valid_q;
        rdy_d         = rdy_q;
        pend_d        = pend_q;
        state_d       = state_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;

        // Wakeup only lands on entries that are already valid before this edge.
        if (wakeup_valid && valid_q[wakeup_idx]) begin
            rdy_d[wakeup_idx] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cand_any) begin
                    state_d             = OFFER;
                    issue_valid_d       = 1'b1;
                    issue_idx_d         = cand_idx;
                    pend_d[cand_idx]    = 1'b1;
                end
            end
            OFFER: begin
                if (issue_ready) begin
                    valid_d[issue_idx_q] = 1'b0;
                    rdy_d[issue_idx_q]   = 1'b0;
                    pend_d[issue_idx_q]  = 1'b0;
                    if (cand_any) begin
                        issue_idx_d      = cand_idx;
                        pend_d[cand_idx] = 1'b1;
                    end else begin
                        state_d       = IDLE;
                        issue_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                issue_valid_d = 1'b0;
            end
        endcase

        if (alloc_fire) begin
            valid_d[free_idx] = 1'b1;
            rdy_d[free_idx]   = alloc_rdy_in;
        end

        count_d = count_q + CW'(alloc_fire) - CW'(issue_fire);

        if (flush) begin
            valid_d       = '0;
            rdy_d         = '0;
            pend_d        = '0;
            state_d       = IDLE;
            issue_valid_d = 1'b0;
            count_d       = '0;
        end

        full_d  = (count_d == CW'(NENT));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q       <= '0;
            rdy_q         <= '0;
            pend_q        <= '0;
            state_q       <= IDLE;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            live_q        <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            rdy_q         <= rdy_d;
            pend_q        <= pend_d;
            state_q       <= state_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            live_q        <= 1'b1;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_idx   = issue_idx_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule
